// File: rtl/tetris_input_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tetris_input_scheduler
// Purpose  : Turns held keys and the level-dependent gravity timer into one
//            stream of move commands over a valid/ready handshake. It also
//            tracks cleared lines to derive the level and the gravity period.
// Ports    : clk, reset (sync, active-high), enable (game running),
//            frame_tick (one pulse per frame), keycode[7:0] (HID, 0 = none),
//            lines_valid / lines_count[2:0] (clear-pass result),
//            cmd_ready (in), cmd_valid / cmd[2:0] (out),
//            level[3:0], gravity_period[5:0] (out)
// Revision : 1.0 - initial release
// ============================================================================
module tetris_input_scheduler #(
  parameter int DAS_FRAMES      = 10,
  parameter int ARR_FRAMES      = 2,
  parameter int BASE_GRAVITY    = 48,
  parameter int GRAVITY_STEP    = 3,
  parameter int MIN_GRAVITY     = 2,
  parameter int LINES_PER_LEVEL = 10,
  parameter int MAX_LEVEL       = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       frame_tick,
  input  logic [7:0] keycode,
  input  logic       lines_valid,
  input  logic [2:0] lines_count,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  output logic [3:0] level,
  output logic [5:0] gravity_period
);

  localparam logic [7:0] KEY_LEFT  = 8'h50;
  localparam logic [7:0] KEY_RIGHT = 8'h4F;
  localparam logic [7:0] KEY_ROT   = 8'h1A;
  localparam logic [7:0] KEY_HOLD  = 8'h06;
  localparam logic [7:0] KEY_HARD  = 8'h2C;
  localparam logic [7:0] KEY_SOFT  = 8'h51;

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_LEFT  = 3'd1;
  localparam logic [2:0] CMD_RIGHT = 3'd2;
  localparam logic [2:0] CMD_ROT   = 3'd3;
  localparam logic [2:0] CMD_SOFT  = 3'd4;
  localparam logic [2:0] CMD_GRAV  = 3'd5;
  localparam logic [2:0] CMD_HARD  = 3'd6;
  localparam logic [2:0] CMD_HOLD  = 3'd7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SELECT = 2'd1;
  localparam logic [1:0] ST_ISSUE  = 2'd2;

  localparam int HOLD_W = $clog2(DAS_FRAMES + ARR_FRAMES + 1);
  localparam logic [HOLD_W-1:0] C_DAS   = HOLD_W'(DAS_FRAMES);
  localparam logic [HOLD_W-1:0] C_REP   = HOLD_W'(DAS_FRAMES + ARR_FRAMES);
  localparam logic [HOLD_W-1:0] C_ONE_H = HOLD_W'(1);
  localparam int LINE_W = $clog2(LINES_PER_LEVEL + 5);
  localparam logic [LINE_W-1:0] C_LPL = LINE_W'(LINES_PER_LEVEL);

  logic [1:0]        state, state_nx;
  logic [7:0]        prev_key;
  logic [HOLD_W-1:0] hold_cnt;
  logic [5:0]        grav_cnt;
  logic [2:0]        cmd_lat;
  logic [LINE_W-1:0] line_acc;
  logic f_left, f_right, f_rot, f_hold, f_hard, f_grav, grav_soft;

  // ---------------- event detection ----------------
  logic key_changed, lr_held, soft_held, repeat_fire, grav_fire;
  logic [HOLD_W-1:0] hold_inc;
  logic [5:0] eff_period;

  assign key_changed = (keycode != prev_key);
  assign lr_held     = !key_changed && (keycode == KEY_LEFT || keycode == KEY_RIGHT);
  assign soft_held   = (keycode == KEY_SOFT);
  assign hold_inc    = hold_cnt + C_ONE_H;
  // First repeat at DAS; afterwards the counter wraps from DAS+ARR back to DAS.
  assign repeat_fire = lr_held && frame_tick && (hold_inc == C_DAS || hold_inc == C_REP);
  assign eff_period  = soft_held ? 6'(MIN_GRAVITY) : gravity_period;
  // ">=" so a counter already past a freshly shortened period fires at once.
  assign grav_fire   = frame_tick && (({1'b0, grav_cnt} + 7'd1) >= {1'b0, eff_period});

  // ---------------- selection ----------------
  logic [2:0] sel_cmd;
  logic any_flag, taking, hard_issue, clr_grav;

  always_comb begin
    sel_cmd = CMD_NONE;
    if (f_hard)       sel_cmd = CMD_HARD;
    else if (f_grav)  sel_cmd = grav_soft ? CMD_SOFT : CMD_GRAV;
    else if (f_hold)  sel_cmd = CMD_HOLD;
    else if (f_rot)   sel_cmd = CMD_ROT;
    else if (f_left)  sel_cmd = CMD_LEFT;
    else if (f_right) sel_cmd = CMD_RIGHT;
  end

  assign any_flag   = f_hard | f_grav | f_hold | f_rot | f_left | f_right;
  assign taking     = (state == ST_SELECT) && enable && any_flag;
  assign hard_issue = taking && (sel_cmd == CMD_HARD);
  assign clr_grav   = taking && (sel_cmd == CMD_GRAV || sel_cmd == CMD_SOFT);

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (enable) state_nx = ST_SELECT;
      ST_SELECT: begin
        if (!enable)       state_nx = ST_IDLE;
        else if (any_flag) state_nx = ST_ISSUE;
      end
      ST_ISSUE:  if (cmd_ready) state_nx = enable ? ST_SELECT : ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid = (state == ST_ISSUE);
    cmd       = cmd_lat;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_key <= 8'h00;
      cmd_lat  <= CMD_NONE;
    end else begin
      prev_key <= keycode;
      if (taking) cmd_lat <= sel_cmd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      hold_cnt <= '0;
      grav_cnt <= 6'd0;
    end else begin
      if (key_changed)                hold_cnt <= '0;
      else if (lr_held && frame_tick) hold_cnt <= (hold_inc == C_REP) ? C_DAS : hold_inc;

      if (hard_issue)      grav_cnt <= 6'd0;
      else if (frame_tick) grav_cnt <= grav_fire ? 6'd0 : grav_cnt + 6'd1;
    end
  end

  // Each flag: set has precedence over the same-cycle clear.
  always_ff @(posedge clk) begin
    if (reset || !enable) begin
      f_left <= 1'b0; f_right <= 1'b0; f_rot <= 1'b0;
      f_hold <= 1'b0; f_hard  <= 1'b0; f_grav <= 1'b0; grav_soft <= 1'b0;
    end else begin
      if (key_changed && keycode == KEY_HARD) f_hard <= 1'b1;
      else if (hard_issue)                    f_hard <= 1'b0;

      if (grav_fire && !hard_issue) begin
        f_grav    <= 1'b1;
        grav_soft <= soft_held;
      end else if (clr_grav || hard_issue) begin
        f_grav    <= 1'b0;
      end

      if (key_changed && keycode == KEY_HOLD)     f_hold <= 1'b1;
      else if (taking && sel_cmd == CMD_HOLD)     f_hold <= 1'b0;

      if (key_changed && keycode == KEY_ROT)      f_rot <= 1'b1;
      else if (taking && sel_cmd == CMD_ROT)      f_rot <= 1'b0;

      if ((key_changed || repeat_fire) && keycode == KEY_LEFT)  f_left <= 1'b1;
      else if (taking && sel_cmd == CMD_LEFT)                   f_left <= 1'b0;

      if ((key_changed || repeat_fire) && keycode == KEY_RIGHT) f_right <= 1'b1;
      else if (taking && sel_cmd == CMD_RIGHT)                  f_right <= 1'b0;
    end
  end

  // ---------------- level tracking (independent of the FSM) ----------------
  logic [LINE_W-1:0] line_sum;
  logic [5:0] gp_next;
  int lvl_dec;

  assign line_sum = line_acc + LINE_W'(lines_count);

  always_comb begin
    lvl_dec = int'(level) * GRAVITY_STEP;
    if (lvl_dec + MIN_GRAVITY >= BASE_GRAVITY) gp_next = 6'(MIN_GRAVITY);
    else                                       gp_next = 6'(BASE_GRAVITY - lvl_dec);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      line_acc       <= '0;
      level          <= 4'd0;
      gravity_period <= 6'(BASE_GRAVITY);
    end else begin
      gravity_period <= gp_next;
      if (lines_valid) begin
        if (line_sum >= C_LPL) begin
          line_acc <= line_sum - C_LPL;
          if (level != 4'(MAX_LEVEL)) level <= level + 4'd1;
        end else begin
          line_acc <= line_sum;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tetris_input_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_tetris_input_scheduler
// Purpose  : Scoreboard bench for tetris_input_scheduler. Expected commands
//            are queued when stimulus is driven and compared at handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tetris_input_scheduler;

  logic       clk = 1'b0;
  logic       reset, enable, frame_tick, lines_valid, cmd_ready;
  logic [7:0] keycode;
  logic [2:0] lines_count;
  logic       cmd_valid, cmd_valid2;
  logic [2:0] cmd, cmd2;
  logic [3:0] level, level2;
  logic [5:0] gravity_period, gravity_period2;

  always #5 clk = ~clk;

  tetris_input_scheduler dut (
    .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
    .keycode(keycode), .lines_valid(lines_valid), .lines_count(lines_count),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd(cmd),
    .level(level), .gravity_period(gravity_period)
  );

  tetris_input_scheduler #(.GRAVITY_STEP(4)) dut_step4 (
    .clk(clk), .reset(reset), .enable(enable), .frame_tick(frame_tick),
    .keycode(keycode), .lines_valid(lines_valid), .lines_count(lines_count),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid2), .cmd(cmd2),
    .level(level2), .gravity_period(gravity_period2)
  );

  int errors = 0;
  int checks = 0;
  int handshakes = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_cmd;
  logic [2:0] dropped;

  // Handshake monitor: inputs only change just after posedge, so a
  // valid&&ready seen at negedge is the handshake of the next edge.
  always @(negedge clk) begin
    if (!reset && cmd_valid && cmd_ready) begin
      handshakes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL handshake_unexpected: got cmd=%0d, expected no command", cmd);
      end else begin
        exp_cmd = exp_q.pop_front();
        if (cmd !== exp_cmd) begin
          errors++;
          $display("FAIL handshake_cmd: got cmd=%0d, expected %0d", cmd, exp_cmd);
        end
      end
    end
  end

  // Leaves the bench 1ns after the n-th following posedge.
  task automatic clk_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int gap);
    frame_tick = 1'b1;
    clk_wait(1);
    frame_tick = 1'b0;
    clk_wait(gap);
  endtask

  task automatic restart();
    enable = 1'b0;
    clk_wait(2);
    enable = 1'b1;
    clk_wait(2);
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; frame_tick = 1'b0; keycode = 8'h00;
    lines_valid = 1'b0; lines_count = 3'd0; cmd_ready = 1'b1;
    clk_wait(3);
    reset = 1'b0;
    clk_wait(1);
    checks++;
    if (cmd_valid !== 1'b0 || cmd !== 3'd0 || level !== 4'd0 ||
        gravity_period !== 6'd48 || gravity_period2 !== 6'd48) begin
      errors++;
      $display("FAIL reset_state: got valid=%0b cmd=%0d level=%0d period=%0d period2=%0d, expected 0 0 0 48 48",
               cmd_valid, cmd, level, gravity_period, gravity_period2);
    end
  endtask

  task automatic test_gravity();
    restart();
    cmd_ready = 1'b0;
    for (int i = 1; i <= 47; i++) tick(1);
    frame_tick = 1'b1;
    exp_q.push_back(3'd5);
    clk_wait(1);
    frame_tick = 1'b0;
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL gravity_latency_early: got valid=%0b, expected 0 one clk after tick", cmd_valid);
    end
    clk_wait(1);
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 3'd5) begin
      errors++;
      $display("FAIL gravity_latency: got valid=%0b cmd=%0d, expected 1 5", cmd_valid, cmd);
    end
    clk_wait(3);
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 3'd5) begin
      errors++;
      $display("FAIL gravity_hold: got valid=%0b cmd=%0d, expected 1 5", cmd_valid, cmd);
    end
    cmd_ready = 1'b1;
    clk_wait(4);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL gravity_single: got valid=%0b, expected 0 after handshake", cmd_valid);
    end
  endtask

  task automatic test_das();
    int h0;
    restart();
    h0 = handshakes;
    keycode = 8'h50;
    exp_q.push_back(3'd1);
    clk_wait(6);
    for (int i = 1; i <= 20; i++) begin
      if (i == 10 || (i > 10 && (i % 2) == 0)) exp_q.push_back(3'd1);
      tick(6);
    end
    keycode = 8'h00;
    clk_wait(6);
    checks++;
    if (handshakes - h0 != 7 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL das_count: got %0d commands (%0d outstanding), expected 7 (0)",
               handshakes - h0, exp_q.size());
    end
  endtask

  task automatic test_rotate_stall();
    int h0;
    restart();
    h0 = handshakes;
    cmd_ready = 1'b0;
    keycode = 8'h1A;
    exp_q.push_back(3'd3);
    clk_wait(2);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (cmd_valid !== 1'b1 || cmd !== 3'd3) begin
        errors++;
        $display("FAIL rotate_stall: got valid=%0b cmd=%0d, expected 1 3", cmd_valid, cmd);
      end
      clk_wait(1);
    end
    cmd_ready = 1'b1;
    clk_wait(4);
    for (int i = 1; i <= 100; i++) begin
      if (i == 48 || i == 96) exp_q.push_back(3'd5);
      tick(4);
    end
    keycode = 8'h00;
    clk_wait(4);
    checks++;
    if (handshakes - h0 != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rotate_once: got %0d commands (%0d outstanding), expected 3 (0)",
               handshakes - h0, exp_q.size());
    end
  endtask

  task automatic test_priority();
    restart();
    for (int i = 1; i <= 47; i++) tick(2);
    // Gravity and ROTATE both set at the same edge.
    keycode = 8'h1A;
    frame_tick = 1'b1;
    exp_q.push_back(3'd5);
    exp_q.push_back(3'd3);
    clk_wait(1);
    frame_tick = 1'b0;
    clk_wait(8);
    keycode = 8'h00;
    clk_wait(2);
    // HARD_DROP restarts the gravity count: next gravity is 48 ticks later.
    for (int i = 1; i <= 10; i++) tick(2);
    keycode = 8'h2C;
    exp_q.push_back(3'd6);
    clk_wait(6);
    keycode = 8'h00;
    clk_wait(2);
    for (int i = 1; i <= 47; i++) tick(3);
    exp_q.push_back(3'd5);
    tick(6);
    // Soft drop held: period shrinks to 2.
    keycode = 8'h51;
    clk_wait(1);
    for (int i = 1; i <= 6; i++) begin
      if ((i % 2) == 0) exp_q.push_back(3'd4);
      tick(5);
    end
    keycode = 8'h00;
    clk_wait(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL priority_drain: got %0d outstanding commands, expected 0", exp_q.size());
    end
  endtask

  task automatic test_enable_drop();
    restart();
    cmd_ready = 1'b0;
    keycode = 8'h1A;
    exp_q.push_back(3'd3);
    clk_wait(3);
    keycode = 8'h50;
    clk_wait(1);
    enable = 1'b0;
    clk_wait(1);
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 3'd3) begin
      errors++;
      $display("FAIL enable_drop_inflight: got valid=%0b cmd=%0d, expected 1 3", cmd_valid, cmd);
    end
    cmd_ready = 1'b1;
    clk_wait(1);
    checks++;
    if (cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL enable_drop_complete: got valid=%0b, expected 0", cmd_valid);
    end
    keycode = 8'h00;
    clk_wait(2);
    enable = 1'b1;
    clk_wait(6);
    checks++;
    if (cmd_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL enable_drop_discard: got valid=%0b outstanding=%0d, expected 0 0",
               cmd_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_mid_issue();
    cmd_ready = 1'b0;
    keycode = 8'h1A;
    exp_q.push_back(3'd3);
    clk_wait(3);
    checks++;
    if (cmd_valid !== 1'b1 || cmd !== 3'd3) begin
      errors++;
      $display("FAIL reset_mid_pre: got valid=%0b cmd=%0d, expected 1 3", cmd_valid, cmd);
    end
    reset = 1'b1;
    keycode = 8'h00;
    clk_wait(1);
    checks++;
    if (cmd_valid !== 1'b0 || cmd !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid_issue: got valid=%0b cmd=%0d, expected 0 0", cmd_valid, cmd);
    end
    dropped = exp_q.pop_front();
    reset = 1'b0;
    cmd_ready = 1'b1;
    clk_wait(4);
  endtask

  task automatic pulse_lines(input logic [2:0] n);
    lines_valid = 1'b1;
    lines_count = n;
    clk_wait(1);
    lines_valid = 1'b0;
    lines_count = 3'd0;
    clk_wait(1);
  endtask

  task automatic test_levels();
    pulse_lines(3'd4);
    pulse_lines(3'd4);
    checks++;
    if (level !== 4'd0) begin
      errors++;
      $display("FAIL level_before: got level=%0d, expected 0", level);
    end
    lines_valid = 1'b1;
    lines_count = 3'd4;
    clk_wait(1);
    lines_valid = 1'b0;
    lines_count = 3'd0;
    checks++;
    if (level !== 4'd1 || gravity_period !== 6'd48) begin
      errors++;
      $display("FAIL level_up: got level=%0d period=%0d, expected 1 48", level, gravity_period);
    end
    clk_wait(1);
    checks++;
    if (gravity_period !== 6'd45 || gravity_period2 !== 6'd44) begin
      errors++;
      $display("FAIL level1_period: got period=%0d period2=%0d, expected 45 44",
               gravity_period, gravity_period2);
    end
    for (int i = 0; i < 37; i++) pulse_lines(3'd4);
    pulse_lines(3'd2);
    clk_wait(2);
    checks++;
    if (level !== 4'd15 || gravity_period !== 6'd3) begin
      errors++;
      $display("FAIL level_saturate: got level=%0d period=%0d, expected 15 3", level, gravity_period);
    end
    checks++;
    if (level2 !== 4'd15 || gravity_period2 !== 6'd2) begin
      errors++;
      $display("FAIL min_gravity: got level=%0d period=%0d, expected 15 2", level2, gravity_period2);
    end
  endtask

  initial begin
    test_reset();
    test_gravity();
    test_das();
    test_rotate_stall();
    test_priority();
    test_enable_drop();
    test_reset_mid_issue();
    test_levels();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL final_queue: got %0d outstanding commands, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
